uart_receiver: RTL
==================

# uart_receiver

- Serial receive stage on the far end of the UART line driven by the team's transmitter.
- Synchronizes `serial_in` and detects a start bit.
- Samples 8 data bits (LSB first) plus one stop bit at mid-bit, using the same cycles-per-bit value as the transmitter.
- Presents each byte to the APB serial register block through a ready/read handshake, with framing and overrun flags.

## Interface
Parameters:
- `NUM_CNT_BITS`, 32: width of the cycle counter and of `baudData`.
- `MIN_DIV`, 4: smallest divisor honoured; smaller `baudData` values are clamped to this.

Ports:
- `clk`  in  1  system clock.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `serial_in`  in  1  asynchronous serial line; idles high.
- `baudData`  in  32  clock cycles per bit (D); 286 for 115200 baud at 33 MHz.
- `data_read`  in  1  single-cycle pulse: the consumer has taken `rx_data`.
- `rx_data`  out  8  last received byte.
- `data_ready`  out  1  `rx_data` holds an unread byte.
- `framing_error`  out  1  stop bit of the byte in `rx_data` was sampled low.
- `overrun_error`  out  1  sticky flag: a byte was overwritten before it was read.
- `busy`  out  1  a frame is in progress (state is not IDLE).

## Operation
- **Synchronizer:** two flops on `serial_in`, both reset to 1. All logic below uses the synchronized value `rx_s` and its previous value `rx_d`.
- **FSM states:** IDLE, START, DATA, STOP, LOAD. Reset state is IDLE.
- **Start detect:** in IDLE, a falling edge (`rx_d`=1, `rx_s`=0) moves the FSM to START.
  - On that edge, `baudData` is latched as the effective divisor `Deff = max(baudData, MIN_DIV)`.
  - The cycle counter clears on the same edge.
  - A line held low (break) produces no edge, so it never retriggers a frame.
- **START:** after `floor(Deff/2)` cycles, sample `rx_s`.
  - Sample = 1: false start; go to IDLE, no output change.
  - Sample = 0: clear the counter and go to DATA.
- **DATA:** every `Deff` cycles, sample and shift into an 8-bit register from the MSB side, so bit 0 is received first. After 8 samples, go to STOP.
- **STOP:** after `Deff` cycles, sample; capture `stop_bad = ~rx_s`. Go to LOAD.
- **LOAD** (one cycle), then back to IDLE:
  - `rx_data <= shift`, `framing_error <= stop_bad`, `data_ready <= 1`.
  - If `data_ready` was already 1 and `data_read` is low this cycle, set `overrun_error`. The newest byte still wins.
- **Handshake:** `data_read` while `data_ready`=1 clears `data_ready` and `overrun_error` on the next edge.
  - `data_read` while `data_ready`=0 is ignored.
  - `data_read` coinciding with LOAD: LOAD wins, `data_ready` stays 1, no overrun.
- **Divisor changes:** a `baudData` change mid-frame has no effect until the next start edge.
- **Reset mid-frame:** all state clears immediately; the partial byte is discarded.

## Timing
- **Reset values:** `rx_data`=0x00, `data_ready`=0, `framing_error`=0, `overrun_error`=0, `busy`=0; synchronizer flops=1.
- **Input latency:** 2 cycles from `serial_in` to `rx_s`.
- **Sample points:** let E be the cycle in which the falling edge is detected.
  - Start-bit sample: E + floor(Deff/2).
  - Data bit k (k = 0..7): E + floor(Deff/2) + (k+1)·Deff.
  - Stop-bit sample: E + floor(Deff/2) + 9·Deff.
- **Output latency:** `rx_data`, `data_ready` and `framing_error` update on the edge 1 cycle after the stop sample.
- **`busy`:** high from E+1 through the LOAD cycle.
- **Back-to-back frames:** IDLE is re-entered at about 9.5·Deff, so a next start edge arriving at 10·Deff (transmitter back-to-back rate) is caught.

## Structure
- **Shared package `serial_pkg`:**
  - `rx_state_t` enum (IDLE, START, DATA, STOP, LOAD).
  - `UART_DATA_BITS`=8 and `MIN_DIV`=4.
  - Also consumed by the transmitter bench.
- **Sub-modules:** reuse the existing `flex_counter` twice, matching the transmitter:
  - a 32-bit cycle counter;
  - a 4-bit bit counter.
  - No new sub-module is needed; the synchronizer stays inline.

## Test plan
- **Loopback:** transmitter `data_out` → `serial_in`, D=16, send 0xA5 → `rx_data`=0xA5, `data_ready`=1, `framing_error`=0, asserted 1 cycle after the stop sample.
- **Framing error:** D=16, bit-bang 0x3C with stop bit = 0 → `rx_data`=0x3C, `framing_error`=1. A following good frame 0x01 → `framing_error`=0.
- **Glitch rejection:** D=16, 3-cycle low pulse on an idle line → returns to IDLE at E+8, `data_ready` stays 0, `busy` pulses only.
- **Overrun:** send 0x11 then 0x22 back-to-back without `data_read` → `rx_data`=0x22, `overrun_error`=1. Then `data_read` → `data_ready`=0, `overrun_error`=0.
- **Simultaneous events:** `data_read` pulsed in the LOAD cycle of 0x33 (previous byte unread) → `data_ready`=1, `rx_data`=0x33, `overrun_error`=0.
- **Reset and divisor clamp:**
  - Assert `n_rst` mid-DATA → all outputs at reset values, then 0x7E received correctly.
  - `baudData`=2 → frame decoded at `Deff`=4.
  - D=286: 0x55 received correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared serial definitions: receiver FSM states, frame width, divisor floor.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Also imported by the transmitter bench.
package serial_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int MIN_DIV        = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        LOAD  = 3'd4
    } rx_state_t;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear and programmable wrap value.
// Latency: count_out updates on the edge after count_enable; wraps to 0 on the step after rollover_val.
// Backpressure: none; holds its value while count_enable is low.
//   clk, n_rst        clock, async active-low reset
//   clear             synchronous clear (priority over count_enable)
//   count_enable      advance by one this cycle
//   rollover_val      last value before wrapping to 0
//   count_out         current count
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    localparam logic [NUM_CNT_BITS-1:0] LP_ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_enable) begin
            if (r_count == rollover_val) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + LP_ONE;
            end
        end
    end

    assign count_out = r_count;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 8N1 frames, LSB first, mid-bit sampling at baudData cycles per bit.
// Latency: 2-cycle input sync; rx_data/data_ready/framing_error update 1 cycle after the stop sample.
// Backpressure: none on the line; an unread byte is overwritten and overrun_error latches.
//   clk, n_rst        clock, async active-low reset
//   serial_in         asynchronous serial line (idles high)
//   baudData          cycles per bit, latched at each start edge, clamped to MIN_DIV
//   data_read         consumer pulse: rx_data has been taken
//   rx_data           last received byte
//   data_ready        rx_data holds an unread byte
//   framing_error     stop bit of rx_data's frame sampled low
//   overrun_error     sticky: a byte was overwritten before being read
//   busy              a frame is in progress
module uart_receiver #(
    parameter int NUM_CNT_BITS = 32,
    parameter int MIN_DIV      = serial_pkg::MIN_DIV
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    serial_in,
    input  logic [NUM_CNT_BITS-1:0] baudData,
    input  logic                    data_read,
    output logic [7:0]              rx_data,
    output logic                    data_ready,
    output logic                    framing_error,
    output logic                    overrun_error,
    output logic                    busy
);

    import serial_pkg::*;

    localparam logic [NUM_CNT_BITS-1:0] LP_MIN_DIV = NUM_CNT_BITS'(MIN_DIV);
    localparam logic [NUM_CNT_BITS-1:0] LP_ONE     = NUM_CNT_BITS'(1);
    localparam logic [3:0]              LP_LAST_BIT = 4'(UART_DATA_BITS - 1);

    // Synchronizer and edge-detect history, all idle-high.
    logic r_sync1;
    logic r_rx_s;
    logic r_rx_d;
    logic w_fall;

    rx_state_t r_state;
    rx_state_t w_next_state;

    logic [NUM_CNT_BITS-1:0]   r_deff;
    logic [NUM_CNT_BITS-1:0]   w_roll_val;
    logic [NUM_CNT_BITS-1:0]   w_cyc_cnt;
    logic [3:0]                w_bit_cnt;
    logic                      w_tick;
    logic                      w_last_bit;

    logic                      w_cnt_clr;
    logic                      w_cnt_en;
    logic                      w_bit_clr;
    logic                      w_bit_en;
    logic                      w_latch_div;
    logic                      w_shift_en;
    logic                      w_stop_en;
    logic                      w_load;

    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_stop_bad;
    logic [UART_DATA_BITS-1:0] r_rx_data;
    logic                      r_data_ready;
    logic                      r_framing_error;
    logic                      r_overrun_error;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= serial_in;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;
        end
    end

    // A held-low line never produces this, so a break cannot retrigger frames.
    assign w_fall = r_rx_d & ~r_rx_s;

    // Cycle counter: in START it wraps at half a bit, otherwise at a full bit,
    // so each wrap is exactly a sample point and the next bit period starts at 0.
    flex_counter #(
        .NUM_CNT_BITS (NUM_CNT_BITS)
    ) u_cyc_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (w_cnt_clr),
        .count_enable (w_cnt_en),
        .rollover_val (w_roll_val),
        .count_out    (w_cyc_cnt)
    );

    flex_counter #(
        .NUM_CNT_BITS (4)
    ) u_bit_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (w_bit_clr),
        .count_enable (w_bit_en),
        .rollover_val (LP_LAST_BIT),
        .count_out    (w_bit_cnt)
    );

    assign w_tick     = (w_cyc_cnt == w_roll_val);
    assign w_last_bit = (w_bit_cnt == LP_LAST_BIT);

    // FSM state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_fall) w_next_state = START;
            START:   if (w_tick) w_next_state = r_rx_s ? IDLE : DATA;
            DATA:    if (w_tick && w_last_bit) w_next_state = STOP;
            STOP:    if (w_tick) w_next_state = LOAD;
            LOAD:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // FSM output logic
    always_comb begin
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        w_bit_clr   = 1'b0;
        w_bit_en    = 1'b0;
        w_latch_div = 1'b0;
        w_shift_en  = 1'b0;
        w_stop_en   = 1'b0;
        w_load      = 1'b0;
        w_roll_val  = r_deff - LP_ONE;
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                w_cnt_clr   = 1'b1;
                w_bit_clr   = 1'b1;
                w_latch_div = w_fall;
            end
            START: begin
                w_cnt_en   = 1'b1;
                w_roll_val = (r_deff >> 1) - LP_ONE;
            end
            DATA: begin
                w_cnt_en   = 1'b1;
                w_shift_en = w_tick;
                w_bit_en   = w_tick;
            end
            STOP: begin
                w_cnt_en  = 1'b1;
                w_stop_en = w_tick;
            end
            LOAD: begin
                w_load = 1'b1;
            end
            default: begin
                w_cnt_clr = 1'b1;
                w_bit_clr = 1'b1;
            end
        endcase
    end

    // Datapath and consumer-facing flags.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_deff          <= LP_MIN_DIV;
            r_shift         <= '0;
            r_stop_bad      <= 1'b0;
            r_rx_data       <= '0;
            r_data_ready    <= 1'b0;
            r_framing_error <= 1'b0;
            r_overrun_error <= 1'b0;
        end else begin
            if (w_latch_div) begin
                r_deff <= (baudData < LP_MIN_DIV) ? LP_MIN_DIV : baudData;
            end
            // Fill from the MSB side so the first bit received ends up in bit 0.
            if (w_shift_en) begin
                r_shift <= {r_rx_s, r_shift[UART_DATA_BITS-1:1]};
            end
            if (w_stop_en) begin
                r_stop_bad <= ~r_rx_s;
            end
            if (w_load) begin
                r_rx_data       <= r_shift;
                r_framing_error <= r_stop_bad;
                r_data_ready    <= 1'b1;
                // A read landing on LOAD consumed the old byte, so nothing was lost.
                if (r_data_ready && !data_read) begin
                    r_overrun_error <= 1'b1;
                end else if (r_data_ready && data_read) begin
                    r_overrun_error <= 1'b0;
                end
            end else if (data_read && r_data_ready) begin
                r_data_ready    <= 1'b0;
                r_overrun_error <= 1'b0;
            end
        end
    end

    assign rx_data       = r_rx_data;
    assign data_ready    = r_data_ready;
    assign framing_error = r_framing_error;
    assign overrun_error = r_overrun_error;

endmodule
